// File: rtl/codix_risc_ibus_pkg.sv
// Shared types for the codix_risc instruction-bus prefetcher.
// Bus command encodings, prefetch FSM states and the queue entry layout.
package codix_risc_ibus_pkg;

    localparam logic [1:0] CMD_IDLE = 2'd0;
    localparam logic [1:0] CMD_READ = 2'd1;

    localparam int PF_ADDR_W = 32;
    localparam int PF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } pf_state_e;

    typedef struct packed {
        logic [PF_ADDR_W-1:0] tag;
        logic [PF_DATA_W-1:0] data;
    } pf_entry_t;

endpackage

// File: rtl/codix_risc_pf_fifo.sv
// Synchronous FIFO holding tagged prefetched words.
// A clear wins over a push arriving in the same cycle.
module codix_risc_pf_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !clear && push)
            mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/codix_risc_ibus_prefetch.sv
// Sequential instruction prefetcher between the core ibus and read-only memory.
// CODIX_RISC_IBUS_PF_STATS_EN adds saturating hit/miss counters.
module codix_risc_ibus_prefetch
    import codix_risc_ibus_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] ibus_A0,
    input  logic [1:0]        ibus_REQCMD0,
    output logic              ibus_REQRESP0,
    output logic [DATA_W-1:0] ibus_Q0,
    output logic              ibus_IFCMD0,
    input  logic              ibus_IFRESP0,
    output logic [ADDR_W-1:0] mem_A0,
    output logic [1:0]        mem_REQCMD0,
    input  logic              mem_REQRESP0,
    input  logic [DATA_W-1:0] mem_Q0,
    input  logic              mem_IFCMD0,
    output logic              mem_IFRESP0
`ifdef CODIX_RISC_IBUS_PF_STATS_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses
`endif
);

    localparam int STRIDE = DATA_W / 8;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int OW     = $clog2(MAX_OUT + 1);
    localparam int SW     = CW + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] tag;
        logic [DATA_W-1:0] data;
    } entry_t;

    pf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pf_addr_q, pf_addr_d;
    logic [OW-1:0]     out_q, out_d;
    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_data_q;

    entry_t            head, push_entry;
    logic [CW-1:0]     count;
    logic [SW-1:0]     fill;
    logic [ADDR_W-1:0] ret_tag, next_exp;
    logic              req, issue, acc, ret, push;
    logic              match, hit, miss;

    assign req   = (ibus_REQCMD0 == CMD_READ);
    assign fill  = SW'(count) + SW'(out_q);
    assign issue = (state_q == STREAM) && (fill < SW'(DEPTH))
                   && (out_q < OW'(MAX_OUT));
    assign acc   = issue && mem_REQRESP0;
    assign ret   = mem_IFCMD0;
    assign out_d = out_q + OW'(acc) - OW'(ret);

    // Responses come back in order, so the oldest read sits out_q words behind pf_addr.
    assign ret_tag  = pf_addr_q - (ADDR_W'(out_q) * ADDR_W'(STRIDE));
    assign next_exp = (count != '0) ? head.tag : ret_tag;
    assign match    = (next_exp == ibus_A0);

    assign hit  = (state_q == STREAM) && req && (count != '0) && match
                  && (!resp_valid_q || ibus_IFRESP0);
    assign miss = (state_q == STREAM) && req && !match;
    assign push = ret && (state_q == STREAM);

    assign push_entry = '{tag: ret_tag, data: mem_Q0};

    codix_risc_pf_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST),
        .push  (push),
        .pop   (hit),
        .clear (miss),
        .wdata (push_entry),
        .rdata (head),
        .count (count)
    );

    always_comb begin
        state_d   = state_q;
        pf_addr_d = pf_addr_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    pf_addr_d = ibus_A0;
                    state_d   = STREAM;
                end
            end
            STREAM: begin
                if (acc)
                    pf_addr_d = pf_addr_q + ADDR_W'(STRIDE);
                if (miss) begin
                    if (out_d != '0)
                        state_d = FLUSH;
                    else
                        pf_addr_d = ibus_A0;
                end
            end
            FLUSH: begin
                if (out_q == '0) begin
                    pf_addr_d = ibus_A0;
                    state_d   = STREAM;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= IDLE;
            pf_addr_q    <= '0;
            out_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            pf_addr_q <= pf_addr_d;
            out_q     <= out_d;
            if (hit) begin
                resp_valid_q <= 1'b1;
                resp_data_q  <= head.data;
            end else if (ibus_IFRESP0) begin
                resp_valid_q <= 1'b0;
            end
        end
    end

`ifdef CODIX_RISC_IBUS_PF_STATS_EN
    always_ff @(posedge CLK) begin
        if (!RST) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else begin
            if (hit && (stat_hits != '1))
                stat_hits <= stat_hits + 32'd1;
            if (miss && (stat_misses != '1))
                stat_misses <= stat_misses + 32'd1;
        end
    end
`endif

    assign ibus_REQRESP0 = hit;
    assign ibus_IFCMD0   = resp_valid_q;
    assign ibus_Q0       = resp_data_q;
    assign mem_A0        = pf_addr_q;
    assign mem_REQCMD0   = issue ? CMD_READ : CMD_IDLE;
    assign mem_IFRESP0   = 1'b1;

endmodule

// File: tb/tb_codix_risc_ibus_prefetch.sv
// Self-checking bench for codix_risc_ibus_prefetch with a queue-level reference model.
// Directed scenarios followed by randomized core/memory traffic.
module tb_codix_risc_ibus_prefetch;
    import codix_risc_ibus_pkg::*;

    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] ibus_A0 = '0;
    logic [1:0]  ibus_REQCMD0 = '0;
    logic        ibus_REQRESP0;
    logic [31:0] ibus_Q0;
    logic        ibus_IFCMD0;
    logic        ibus_IFRESP0 = 1'b0;
    logic [31:0] mem_A0;
    logic [1:0]  mem_REQCMD0;
    logic        mem_REQRESP0 = 1'b0;
    logic [31:0] mem_Q0 = '0;
    logic        mem_IFCMD0 = 1'b0;
    logic        mem_IFRESP0;
`ifdef CODIX_RISC_IBUS_PF_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    codix_risc_ibus_prefetch #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .DEPTH   (DEPTH),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .ibus_A0       (ibus_A0),
        .ibus_REQCMD0  (ibus_REQCMD0),
        .ibus_REQRESP0 (ibus_REQRESP0),
        .ibus_Q0       (ibus_Q0),
        .ibus_IFCMD0   (ibus_IFCMD0),
        .ibus_IFRESP0  (ibus_IFRESP0),
        .mem_A0        (mem_A0),
        .mem_REQCMD0   (mem_REQCMD0),
        .mem_REQRESP0  (mem_REQRESP0),
        .mem_Q0        (mem_Q0),
        .mem_IFCMD0    (mem_IFCMD0),
        .mem_IFRESP0   (mem_IFRESP0)
`ifdef CODIX_RISC_IBUS_PF_STATS_EN
        ,
        .stat_hits     (stat_hits),
        .stat_misses   (stat_misses)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    // stimulus requested for the next cycle
    logic        c_rst = 1'b0;
    logic [1:0]  c_cmd = CMD_IDLE;
    logic [31:0] c_addr = '0;
    logic        c_ifresp = 1'b1;
    int          lat = 1;
    int          acc_pct = 100;
    int          cyc = 0;

    // reference model
    int          mode = 0;
    logic [31:0] nxt = '0;
    logic [31:0] fq[$];
    logic [31:0] inflight[$];
    logic        rv = 1'b0;
    logic [31:0] rd = '0;
    int          mh = 0;
    int          mm = 0;

    // memory responder
    logic [31:0] pend_a[$];
    int          pend_due[$];

    // DUT handshakes seen in the last cycle
    bit          s_hit, s_acc, s_ret;
    logic [31:0] s_acc_addr;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string nm, input int lim);
        checks++;
        failures++;
        $display("FAIL %s: event missing within %0d cycles", nm, lim);
    endtask

    task automatic model_reset();
        mode = 0;
        nxt  = '0;
        fq.delete();
        inflight.delete();
        rv = 1'b0;
        rd = '0;
        mh = 0;
        mm = 0;
    endtask

    task automatic model_cycle(input bit d_mrr, input bit d_mvalid);
        bit          req, m_hit, m_miss, m_issue, acc;
        logic [31:0] expn, hd, t;
        int          n_in0, n_fq;
        req   = (c_cmd == CMD_READ);
        n_in0 = inflight.size();
        n_fq  = fq.size();
        hd    = (n_fq > 0) ? fq[0] : 32'h0;
        expn  = (n_fq > 0) ? hd : ((n_in0 > 0) ? inflight[0] : nxt);
        m_hit   = (mode == 1) && req && (n_fq > 0) && (hd == c_addr)
                  && (!rv || c_ifresp);
        m_miss  = (mode == 1) && req && (expn != c_addr);
        m_issue = (mode == 1) && (n_fq + n_in0 < DEPTH) && (n_in0 < MAX_OUT);

        chk("reqresp", {31'b0, ibus_REQRESP0}, {31'b0, m_hit});
        chk("ifcmd", {31'b0, ibus_IFCMD0}, {31'b0, rv});
        if (rv)
            chk("q0", ibus_Q0, rd);
        chk("mem_cmd", {30'b0, mem_REQCMD0}, m_issue ? 32'd1 : 32'd0);
        if (m_issue)
            chk("mem_a", mem_A0, nxt);
        chk("mem_ifresp", {31'b0, mem_IFRESP0}, 32'd1);
`ifdef CODIX_RISC_IBUS_PF_STATS_EN
        chk("stat_hits", stat_hits, mh);
        chk("stat_misses", stat_misses, mm);
`endif

        acc = m_issue && d_mrr;
        if (rv && c_ifresp)
            rv = 1'b0;
        if (m_hit) begin
            t  = fq.pop_front();
            rv = 1'b1;
            rd = mem_data(t);
            mh++;
        end
        if (m_miss)
            mm++;
        if (acc) begin
            inflight.push_back(nxt);
            nxt = nxt + 32'd4;
        end
        if (d_mvalid && inflight.size() > 0) begin
            t = inflight.pop_front();
            if (mode == 1 && !m_miss)
                fq.push_back(t);
        end
        case (mode)
            0: if (req) begin
                mode = 1;
                nxt  = c_addr;
            end
            1: if (m_miss) begin
                fq.delete();
                if (inflight.size() > 0)
                    mode = 2;
                else
                    nxt = c_addr;
            end
            default: if (n_in0 == 0) begin
                mode = 1;
                nxt  = c_addr;
            end
        endcase
    endtask

    task automatic step();
        bit d_mvalid, d_mrr;
        @(negedge CLK);
        RST          = c_rst;
        ibus_REQCMD0 = c_cmd;
        ibus_A0      = c_addr;
        ibus_IFRESP0 = c_ifresp;
        d_mvalid     = (pend_a.size() > 0) && (pend_due[0] <= cyc);
        mem_IFCMD0   = d_mvalid;
        mem_Q0       = d_mvalid ? mem_data(pend_a[0]) : 32'h0;
        d_mrr        = ($urandom_range(99) < acc_pct);
        mem_REQRESP0 = d_mrr;
        #1;
        s_hit      = ibus_REQRESP0;
        s_acc      = (mem_REQCMD0 == CMD_READ) && d_mrr;
        s_acc_addr = mem_A0;
        s_ret      = d_mvalid;
        if (RST) begin
            model_cycle(d_mrr, d_mvalid);
            if (d_mvalid) begin
                void'(pend_a.pop_front());
                void'(pend_due.pop_front());
            end
            if (s_acc) begin
                pend_a.push_back(mem_A0);
                pend_due.push_back(cyc + lat);
            end
        end else begin
            model_reset();
            pend_a.delete();
            pend_due.delete();
        end
        cyc++;
    endtask

    task automatic do_reset();
        c_rst = 1'b0;
        c_cmd = CMD_IDLE;
        c_ifresp = 1'b1;
        step();
        c_rst = 1'b1;
    endtask

    task automatic check_reset_outputs(input string p);
        chk({p, "_reqresp"}, {31'b0, ibus_REQRESP0}, 32'd0);
        chk({p, "_ifcmd"}, {31'b0, ibus_IFCMD0}, 32'd0);
        chk({p, "_q0"}, ibus_Q0, 32'd0);
        chk({p, "_mem_a"}, mem_A0, 32'd0);
        chk({p, "_mem_cmd"}, {30'b0, mem_REQCMD0}, 32'd0);
        chk({p, "_mem_ifresp"}, {31'b0, mem_IFRESP0}, 32'd1);
    endtask

    task automatic run_until_hit(input string nm, input int lim);
        bit got = 0;
        for (int i = 0; i < lim && !got; i++) begin
            step();
            if (s_hit)
                got = 1;
        end
        if (!got)
            bound_fail(nm, lim);
    endtask

    task automatic run_until_inflight2(input string nm, input int lim);
        bit got = 0;
        for (int i = 0; i < lim && !got; i++) begin
            step();
            if (s_hit)
                c_addr = c_addr + 32'd4;
            if (inflight.size() == 2)
                got = 1;
        end
        if (!got)
            bound_fail(nm, lim);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          nh, first, last, drops;
        bit          got;
        logic [31:0] first_a;
        logic [31:0] wa [3];
        int          nacc;

        // reset state
        do_reset();
        do_reset();
        step();
        check_reset_outputs("rst");

        // sequential stream, latency 1
        lat = 1;
        acc_pct = 100;
        c_addr = 32'h100;
        c_cmd = CMD_READ;
        nh = 0;
        first = 0;
        last = 0;
        for (int i = 0; i < 40 && nh < 8; i++) begin
            step();
            if (s_acc)
                chk("seq_ahead", {31'b0, (s_acc_addr - c_addr) <= 32'(DEPTH * 4)}, 32'd1);
            if (s_hit) begin
                if (nh == 0)
                    first = cyc;
                last = cyc;
                nh++;
                c_addr = c_addr + 32'd4;
            end
        end
        chk("seq_hits", nh, 8);
        chk("seq_b2b", last - first, 7);
        c_cmd = CMD_IDLE;
        step();
        chk("seq_last_q", ibus_Q0, mem_data(32'h11C));

        // branch with two reads in flight
        do_reset();
        lat = 4;
        c_addr = 32'h100;
        c_cmd = CMD_READ;
        run_until_inflight2("br_fill", 50);
        c_addr = 32'h400;
        drops = 0;
        got = 0;
        first_a = '0;
        for (int i = 0; i < 60 && !got; i++) begin
            step();
            if (s_ret)
                drops++;
            if (s_acc) begin
                got = 1;
                first_a = s_acc_addr;
            end
        end
        if (!got)
            bound_fail("br_issue", 60);
        chk("br_addr", first_a, 32'h400);
        chk("br_drops", drops, 2);
        run_until_hit("br_hit", 40);
        c_cmd = CMD_IDLE;
        step();
        chk("br_q_valid", {31'b0, ibus_IFCMD0}, 32'd1);
        chk("br_q", ibus_Q0, mem_data(32'h400));

        // core backpressure
        do_reset();
        lat = 1;
        c_addr = 32'h200;
        c_cmd = CMD_READ;
        run_until_hit("bp_hit", 20);
        c_ifresp = 1'b0;
        c_addr = 32'h204;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_valid", {31'b0, ibus_IFCMD0}, 32'd1);
            chk("bp_q", ibus_Q0, mem_data(32'h200));
        end
        chk("bp_issue_stop", {30'b0, mem_REQCMD0}, 32'd0);
        c_ifresp = 1'b1;
        nh = 0;
        for (int i = 0; i < 30 && nh < 3; i++) begin
            step();
            if (s_hit) begin
                nh++;
                c_addr = c_addr + 32'd4;
            end
        end
        chk("bp_resume", nh, 3);

        // address wrap
        do_reset();
        lat = 1;
        c_addr = 32'hFFFF_FFF8;
        c_cmd = CMD_READ;
        nh = 0;
        nacc = 0;
        for (int i = 0; i < 40 && nh < 3; i++) begin
            step();
            if (s_acc && nacc < 3) begin
                wa[nacc] = s_acc_addr;
                nacc++;
            end
            if (s_hit) begin
                nh++;
                c_addr = c_addr + 32'd4;
            end
        end
        chk("wrap_hits", nh, 3);
        chk("wrap_a0", wa[0], 32'hFFFF_FFF8);
        chk("wrap_a1", wa[1], 32'hFFFF_FFFC);
        chk("wrap_a2", wa[2], 32'h0000_0000);
        c_cmd = CMD_IDLE;
        step();
        chk("wrap_q", ibus_Q0, mem_data(32'h0));

        // reset while two reads are outstanding
        do_reset();
        lat = 4;
        c_addr = 32'h300;
        c_cmd = CMD_READ;
        run_until_inflight2("mid_fill", 50);
        do_reset();
        step();
        check_reset_outputs("mid");

`ifdef CODIX_RISC_IBUS_PF_STATS_EN
        // six hits then one branch
        do_reset();
        lat = 1;
        c_addr = 32'h100;
        c_cmd = CMD_READ;
        nh = 0;
        for (int i = 0; i < 40 && nh < 6; i++) begin
            step();
            if (s_hit) begin
                nh++;
                c_addr = c_addr + 32'd4;
            end
        end
        c_addr = 32'h400;
        step();
        c_cmd = CMD_IDLE;
        step();
        step();
        chk("stats_hits", stat_hits, 32'd6);
        chk("stats_misses", stat_misses, 32'd1);
`endif

        // randomized traffic
        do_reset();
        acc_pct = 70;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0)
                lat = $urandom_range(1, 4);
            c_rst = ($urandom_range(399) != 0);
            c_cmd = ($urandom_range(99) < 80) ? CMD_READ : CMD_IDLE;
            c_ifresp = ($urandom_range(99) < 75);
            if ($urandom_range(99) < 4)
                c_addr = 32'h1000 + {$urandom_range(0, 63), 2'b00};
            step();
            if (s_hit)
                c_addr = c_addr + 32'd4;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
